// File: rtl/tile_loop_controller.sv
// rtl/tile_loop_controller.sv - N x M tile loop sequencer for a weight-stationary GEMM (optional perf counters: TILE_CTRL_PERF_EN)
module tile_loop_controller #(
    parameter int ARRAY_ROW = 8,
    parameter int ARRAY_COL = 8,
    parameter int DIM_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ap_start,
    input  logic [DIM_W-1:0] cfg_k_dim,
    input  logic [DIM_W-1:0] cfg_m_tiles,
    input  logic [DIM_W-1:0] cfg_n_tiles,
    output logic             ap_idle,
    output logic             ap_done,
    output logic             ap_err,
    output logic [2:0]       state_dbg,
    output logic [DIM_W-1:0] tile_m_idx,
    output logic [DIM_W-1:0] tile_n_idx,
    output logic             ctrl_weight_load_en,
    input  logic             w_valid,
    output logic             ctrl_input_stream_en,
    input  logic             in_valid,
    output logic             ctrl_acc_clear,
    output logic             ctrl_acc_en,
    output logic             ctrl_drain_en,
`ifdef TILE_CTRL_PERF_EN
    output logic [31:0]      perf_cycles,
    output logic [31:0]      perf_stall_w,
    output logic [31:0]      perf_stall_in,
    output logic [31:0]      perf_stall_out,
`endif
    input  logic             out_ready
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_W  = 3'd1;
    localparam logic [2:0] S_COMPUTE = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [DIM_W-1:0] W_LAST = DIM_W'(ARRAY_ROW - 1);
    localparam logic [DIM_W-1:0] D_LAST = DIM_W'(ARRAY_COL - 1);
    localparam logic [DIM_W-1:0] ONE    = DIM_W'(1);

    logic [2:0]       state_q, state_d;
    logic [DIM_W-1:0] w_cnt_q, w_cnt_d;
    logic [DIM_W-1:0] k_cnt_q, k_cnt_d;
    logic [DIM_W-1:0] d_cnt_q, d_cnt_d;
    logic [DIM_W-1:0] m_idx_q, m_idx_d;
    logic [DIM_W-1:0] n_idx_q, n_idx_d;
    logic [DIM_W-1:0] k_dim_q, k_dim_d;
    logic [DIM_W-1:0] m_tiles_q, m_tiles_d;
    logic [DIM_W-1:0] n_tiles_q, n_tiles_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             start_acc;
    logic             zero_dim;

    assign start_acc = (state_q == S_IDLE) && ap_start;
    assign zero_dim  = (cfg_k_dim == '0) || (cfg_m_tiles == '0) || (cfg_n_tiles == '0);

    // Next-state and counter logic; every phase exits on the edge that accepts its last beat
    always_comb begin
        state_d   = state_q;
        w_cnt_d   = w_cnt_q;
        k_cnt_d   = k_cnt_q;
        d_cnt_d   = d_cnt_q;
        m_idx_d   = m_idx_q;
        n_idx_d   = n_idx_q;
        k_dim_d   = k_dim_q;
        m_tiles_d = m_tiles_q;
        n_tiles_d = n_tiles_q;
        err_d     = err_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    k_dim_d   = cfg_k_dim;
                    m_tiles_d = cfg_m_tiles;
                    n_tiles_d = cfg_n_tiles;
                    w_cnt_d   = '0;
                    k_cnt_d   = '0;
                    d_cnt_d   = '0;
                    m_idx_d   = '0;
                    n_idx_d   = '0;
                    err_d     = zero_dim;
                    if (zero_dim) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD_W;
                    end
                end
            end
            S_LOAD_W: begin
                if (w_valid) begin
                    if (w_cnt_q == W_LAST) begin
                        w_cnt_d = '0;
                        m_idx_d = '0;
                        state_d = S_COMPUTE;
                    end else begin
                        w_cnt_d = w_cnt_q + ONE;
                    end
                end
            end
            S_COMPUTE: begin
                if (in_valid) begin
                    if (k_cnt_q == k_dim_q - ONE) begin
                        k_cnt_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        k_cnt_d = k_cnt_q + ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    if (d_cnt_q == D_LAST) begin
                        d_cnt_d = '0;
                        if (m_idx_q < m_tiles_q - ONE) begin
                            m_idx_d = m_idx_q + ONE;
                            state_d = S_COMPUTE;
                        end else if (n_idx_q < n_tiles_q - ONE) begin
                            n_idx_d = n_idx_q + ONE;
                            m_idx_d = '0;
                            state_d = S_LOAD_W;
                        end else begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        d_cnt_d = d_cnt_q + ONE;
                    end
                end
            end
            S_DONE: begin
                // Leaving only on a low start forces a fresh low-then-high edge for the next run
                if (!ap_start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and shadow-config registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            w_cnt_q   <= '0;
            k_cnt_q   <= '0;
            d_cnt_q   <= '0;
            m_idx_q   <= '0;
            n_idx_q   <= '0;
            k_dim_q   <= '0;
            m_tiles_q <= '0;
            n_tiles_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_cnt_q   <= w_cnt_d;
            k_cnt_q   <= k_cnt_d;
            d_cnt_q   <= d_cnt_d;
            m_idx_q   <= m_idx_d;
            n_idx_q   <= n_idx_d;
            k_dim_q   <= k_dim_d;
            m_tiles_q <= m_tiles_d;
            n_tiles_q <= n_tiles_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign ap_idle              = (state_q == S_IDLE);
    assign ap_done              = done_q;
    assign ap_err               = err_q;
    assign state_dbg            = state_q;
    assign tile_m_idx           = m_idx_q;
    assign tile_n_idx           = n_idx_q;
    assign ctrl_weight_load_en  = (state_q == S_LOAD_W);
    assign ctrl_input_stream_en = (state_q == S_COMPUTE);
    assign ctrl_drain_en        = (state_q == S_DRAIN);
    // in_valid is registered upstream, so this single Mealy term adds no long combinational path
    assign ctrl_acc_en          = (state_q == S_COMPUTE) && in_valid;
    assign ctrl_acc_clear       = (state_q == S_COMPUTE) && (k_cnt_q == '0);

`ifdef TILE_CTRL_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_stall_w_q, perf_stall_w_d;
    logic [31:0] perf_stall_in_q, perf_stall_in_d;
    logic [31:0] perf_stall_out_q, perf_stall_out_d;

    // Busy and per-phase stall accounting, restarted on each accepted start
    always_comb begin
        perf_cycles_d    = perf_cycles_q;
        perf_stall_w_d   = perf_stall_w_q;
        perf_stall_in_d  = perf_stall_in_q;
        perf_stall_out_d = perf_stall_out_q;
        if (start_acc) begin
            perf_cycles_d    = '0;
            perf_stall_w_d   = '0;
            perf_stall_in_d  = '0;
            perf_stall_out_d = '0;
        end else begin
            if (ctrl_weight_load_en || ctrl_input_stream_en || ctrl_drain_en) begin
                perf_cycles_d = perf_cycles_q + 32'd1;
            end
            if (ctrl_weight_load_en && !w_valid) begin
                perf_stall_w_d = perf_stall_w_q + 32'd1;
            end
            if (ctrl_input_stream_en && !in_valid) begin
                perf_stall_in_d = perf_stall_in_q + 32'd1;
            end
            if (ctrl_drain_en && !out_ready) begin
                perf_stall_out_d = perf_stall_out_q + 32'd1;
            end
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles_q    <= '0;
            perf_stall_w_q   <= '0;
            perf_stall_in_q  <= '0;
            perf_stall_out_q <= '0;
        end else begin
            perf_cycles_q    <= perf_cycles_d;
            perf_stall_w_q   <= perf_stall_w_d;
            perf_stall_in_q  <= perf_stall_in_d;
            perf_stall_out_q <= perf_stall_out_d;
        end
    end

    assign perf_cycles    = perf_cycles_q;
    assign perf_stall_w   = perf_stall_w_q;
    assign perf_stall_in  = perf_stall_in_q;
    assign perf_stall_out = perf_stall_out_q;
`else
    logic unused_start;
    assign unused_start = start_acc;
`endif

endmodule

// File: tb/tb_tile_loop_controller.sv
// tb/tb_tile_loop_controller.sv - directed self-checking bench for tile_loop_controller
module tb_tile_loop_controller;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ap_start;
    logic [DW-1:0] cfg_k_dim, cfg_m_tiles, cfg_n_tiles;
    logic          ap_idle, ap_done, ap_err;
    logic [2:0]    state_dbg;
    logic [DW-1:0] tile_m_idx, tile_n_idx;
    logic          ctrl_weight_load_en, w_valid;
    logic          ctrl_input_stream_en, in_valid;
    logic          ctrl_acc_clear, ctrl_acc_en, ctrl_drain_en, out_ready;
`ifdef TILE_CTRL_PERF_EN
    logic [31:0]   perf_cycles, perf_stall_w, perf_stall_in, perf_stall_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor accumulators (written only by the monitor process)
    int       mon_busy = 0, mon_done = 0, mon_wl = 0, mon_acc = 0, mon_clr = 0, mon_comp = 0;
    int       log_n = 0;
    logic [7:0] tile_log [0:63];
    logic [2:0] prev_state = 3'd0;

    // Stimulus mode for in_valid, written only by the main initial block
    logic tog_mode = 1'b0;
    logic phase = 1'b0;

    tile_loop_controller #(.ARRAY_ROW(4), .ARRAY_COL(4), .DIM_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .ap_start(ap_start),
        .cfg_k_dim(cfg_k_dim), .cfg_m_tiles(cfg_m_tiles), .cfg_n_tiles(cfg_n_tiles),
        .ap_idle(ap_idle), .ap_done(ap_done), .ap_err(ap_err), .state_dbg(state_dbg),
        .tile_m_idx(tile_m_idx), .tile_n_idx(tile_n_idx),
        .ctrl_weight_load_en(ctrl_weight_load_en), .w_valid(w_valid),
        .ctrl_input_stream_en(ctrl_input_stream_en), .in_valid(in_valid),
        .ctrl_acc_clear(ctrl_acc_clear), .ctrl_acc_en(ctrl_acc_en),
        .ctrl_drain_en(ctrl_drain_en),
`ifdef TILE_CTRL_PERF_EN
        .perf_cycles(perf_cycles), .perf_stall_w(perf_stall_w),
        .perf_stall_in(perf_stall_in), .perf_stall_out(perf_stall_out),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !ap_done; i++) tick();
        check_eq(tag, {31'd0, ap_done}, 32'd1);
    endtask

    task automatic set_cfg(input int k, input int m, input int n);
        cfg_k_dim   = DW'(k);
        cfg_m_tiles = DW'(m);
        cfg_n_tiles = DW'(n);
    endtask

    // in_valid driver: held high, or toggling 0,1,0,1... from the first COMPUTE cycle
    always @(posedge clk) begin
        #1;
        if (!tog_mode) begin
            in_valid = 1'b1;
            phase    = 1'b0;
        end else if (state_dbg == 3'd2) begin
            in_valid = phase;
            phase    = ~phase;
        end else begin
            in_valid = 1'b0;
            phase    = 1'b0;
        end
    end

    // Cycle monitor sampled on the falling edge
    always @(negedge clk) begin
        if (state_dbg == 3'd1 || state_dbg == 3'd2 || state_dbg == 3'd3) mon_busy++;
        if (ap_done) mon_done++;
        if (ctrl_weight_load_en) mon_wl++;
        if (ctrl_acc_en) mon_acc++;
        if (ctrl_acc_clear && ctrl_acc_en) mon_clr++;
        if (ctrl_input_stream_en) mon_comp++;
        if (state_dbg == 3'd2 && prev_state != 3'd2 && log_n < 64) begin
            tile_log[log_n] = {tile_n_idx[3:0], tile_m_idx[3:0]};
            log_n++;
        end
        prev_state = state_dbg;
    end

    initial begin
        int b_busy, b_done, b_wl, b_acc, b_clr, b_comp, b_log;
        rst_n     = 1'b0;
        ap_start  = 1'b0;
        w_valid   = 1'b1;
        out_ready = 1'b1;
        set_cfg(3, 2, 2);
        tick(); tick();
        check_eq("rst_state", {29'd0, state_dbg}, 32'd0);
        check_eq("rst_idle", {31'd0, ap_idle}, 32'd1);
        check_eq("rst_outs", {26'd0, ap_done, ap_err, ctrl_weight_load_en,
                 ctrl_input_stream_en, ctrl_acc_clear, ctrl_drain_en}, 32'd0);
        check_eq("rst_idx", {tile_n_idx, tile_m_idx}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Full run, all handshakes high: 2*(4+2*(3+4)) = 36 busy cycles
        b_busy = mon_busy; b_done = mon_done; b_wl = mon_wl; b_log = log_n;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        check_eq("run1_start_state", {29'd0, state_dbg}, 32'd1);
        check_eq("run1_idle_low", {31'd0, ap_idle}, 32'd0);
        wait_done("run1_done", 200);
        tick(); tick(); tick();
        check_eq("run1_busy", mon_busy - b_busy, 36);
        check_eq("run1_done_pulses", mon_done - b_done, 1);
        check_eq("run1_wl_cycles", mon_wl - b_wl, 8);
        check_eq("run1_tiles", log_n - b_log, 4);
        check_eq("run1_tile0", {24'd0, tile_log[b_log]},   32'h00);
        check_eq("run1_tile1", {24'd0, tile_log[b_log+1]}, 32'h01);
        check_eq("run1_tile2", {24'd0, tile_log[b_log+2]}, 32'h10);
        check_eq("run1_tile3", {24'd0, tile_log[b_log+3]}, 32'h11);
        check_eq("run1_back_idle", {29'd0, state_dbg}, 32'd0);

        // Toggling in_valid: each COMPUTE takes 6 cycles, 3 accepted beats, one clear beat
        tog_mode = 1'b1;
        b_busy = mon_busy; b_acc = mon_acc; b_clr = mon_clr; b_comp = mon_comp;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        wait_done("tog_done", 300);
        tick();
        check_eq("tog_busy", mon_busy - b_busy, 48);
        check_eq("tog_compute_cycles", mon_comp - b_comp, 24);
        check_eq("tog_acc_en", mon_acc - b_acc, 12);
        check_eq("tog_acc_clear", mon_clr - b_clr, 4);
`ifdef TILE_CTRL_PERF_EN
        check_eq("tog_perf_stall_in", perf_stall_in, 32'd12);
        check_eq("tog_perf_cycles", perf_cycles, 32'd48);
        check_eq("tog_perf_stall_w", perf_stall_w, 32'd0);
`endif
        tog_mode = 1'b0;
        tick();

        // out_ready low for 5 cycles after two drain beats
        set_cfg(3, 1, 1);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        for (int i = 0; i < 50 && state_dbg != 3'd3; i++) tick();
        check_eq("stall_reach_drain", {29'd0, state_dbg}, 32'd3);
        tick(); tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_hold_drain", {29'd0, state_dbg}, 32'd3);
            check_eq("stall_drain_en", {31'd0, ctrl_drain_en}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check_eq("stall_third_beat", {29'd0, state_dbg}, 32'd3);
        tick();
        check_eq("stall_done_state", {29'd0, state_dbg}, 32'd4);
        check_eq("stall_done_pulse", {31'd0, ap_done}, 32'd1);
`ifdef TILE_CTRL_PERF_EN
        check_eq("stall_perf_out", perf_stall_out, 32'd5);
`endif
        tick();

        // Zero K: straight to DONE with error, no enables
        set_cfg(0, 2, 2);
        ap_start = 1'b1;
        tick();
        check_eq("zk_state", {29'd0, state_dbg}, 32'd4);
        check_eq("zk_done", {31'd0, ap_done}, 32'd1);
        check_eq("zk_err", {31'd0, ap_err}, 32'd1);
        check_eq("zk_enables", {29'd0, ctrl_weight_load_en, ctrl_input_stream_en, ctrl_drain_en}, 32'd0);
        ap_start = 1'b0;
        tick();
        check_eq("zk_idle", {29'd0, state_dbg}, 32'd0);
        check_eq("zk_err_sticky", {31'd0, ap_err}, 32'd1);
        set_cfg(3, 1, 1);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        check_eq("zk_err_cleared", {31'd0, ap_err}, 32'd0);
        check_eq("zk_restart_state", {29'd0, state_dbg}, 32'd1);
        wait_done("zk_run_done", 100);
        tick();

        // ap_start held after done: no re-accept, no second pulse
        set_cfg(1, 1, 1);
        b_done = mon_done;
        ap_start = 1'b1;
        tick();
        wait_done("hold_done", 100);
        for (int i = 0; i < 4; i++) tick();
        check_eq("hold_state", {29'd0, state_dbg}, 32'd4);
        check_eq("hold_pulses", mon_done - b_done, 1);
        ap_start = 1'b0;
        tick();
        check_eq("hold_release_idle", {29'd0, state_dbg}, 32'd0);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        check_eq("hold_restart", {29'd0, state_dbg}, 32'd1);
        wait_done("hold_second_done", 100);
        tick();

        // Async reset on cycle 10 of a run (mid-COMPUTE)
        set_cfg(8, 1, 1);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check_eq("mrst_pre_state", {29'd0, state_dbg}, 32'd2);
        b_done = mon_done;
        rst_n = 1'b0;
        #1;
        check_eq("mrst_state", {29'd0, state_dbg}, 32'd0);
        check_eq("mrst_idle", {31'd0, ap_idle}, 32'd1);
        check_eq("mrst_outs", {26'd0, ap_done, ap_err, ctrl_weight_load_en,
                 ctrl_input_stream_en, ctrl_acc_clear, ctrl_drain_en}, 32'd0);
        check_eq("mrst_idx", {tile_n_idx, tile_m_idx}, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check_eq("mrst_no_done", mon_done - b_done, 0);
        check_eq("mrst_stay_idle", {29'd0, state_dbg}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
